// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory request interface.
// Holds the responder state encoding, burst-length constants, default bus
// widths and the address range helper.
package mem_if_pkg;

    localparam int LEN_W      = 3;   // width of req_len (beats minus one)
    localparam int MAX_BURST  = 8;   // largest burst, 2**LEN_W beats
    localparam int WAIT_W     = 3;   // wait-state counter width (0..7)
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RESP   = 3'd3,
        ST_WDATA  = 3'd4
    } state_t;

    // An address is out of range when any bit at or above depth_log2 is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr,
                                               input int          depth_log2);
        return ((addr >> depth_log2) != 32'd0);
    endfunction

endpackage

// File: rtl/mem_sp_array.sv
// Single-port synchronous RAM with write enable and registered read.
// Contents are not reset.
// Ports:
//   clk     - clock
//   i_en    - access enable (read or write this cycle)
//   i_we    - 1 = write i_wdata, 0 = register the addressed word on o_rdata
//   i_addr  - word address
//   i_wdata - write data
//   o_rdata - read data, valid the cycle after a read access
module mem_sp_array #(
    parameter int DEPTH_LOG2 = 8,
    parameter int DATA_W     = 16
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic [DATA_W-1:0]     i_wdata,
    output logic [DATA_W-1:0]     o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(32'd1 << DEPTH_LOG2) - 32'd1];
    logic [DATA_W-1:0] r_rdata;

    // Storage array: write when enabled, otherwise register the read word.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle processor memory port.
// Accepts single and burst (up to 8 beats) read/write requests, inserts
// WAIT_CYC wait states before each beat and services the beat against an
// internal single-port RAM. Each read beat produces a one-cycle response;
// a write request produces one response after its final beat.
// Ports:
//   clk, proc_rst            - clock, asynchronous active-high reset
//   req_valid/req_ready      - request handshake
//   req_write/addr/wdata/len - request attributes, first write beat data
//   wdata_valid/ready/wdata  - handshake for subsequent write beats
//   rsp_valid/rdata/last/err - response pulse and its payload
//   busy                     - high whenever the responder is not idle
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT_CYC   = 1
) (
    input  logic              clk,
    input  logic              proc_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              busy
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYC);
    // State entered at the start of every beat: skip WAIT when no wait states.
    localparam state_t ST_START = state_t'((WAIT_CYC > 0) ? ST_WAIT : ST_ACCESS);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_beat;
    logic [WAIT_W-1:0]   r_wait;
    logic                r_err;
    logic                r_oor;     // current beat was out of range
    logic                w_oor;
    logic                w_last;
    logic                w_ram_en;
    logic                w_ram_we;
    logic [DATA_W-1:0]   w_ram_rdata;

    assign w_oor  = addr_out_of_range(32'(r_addr), DEPTH_LOG2);
    assign w_last = (r_beat == r_len);

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_next = ST_START;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_wait == 3'd1) begin
                    w_next = ST_ACCESS;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_ACCESS: begin
                if (!r_write || w_last) begin
                    w_next = ST_RESP;
                end else begin
                    w_next = ST_WDATA;
                end
            end
            ST_RESP: begin
                // Only read bursts continue after a response; writes answer once.
                if (!r_write && !w_last) begin
                    w_next = ST_START;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WDATA: begin
                if (wdata_valid) begin
                    w_next = ST_START;
                end else begin
                    w_next = ST_WDATA;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register and request/beat datapath.
    always_ff @(posedge clk or posedge proc_rst) begin
        if (proc_rst) begin
            r_state <= ST_IDLE;
            r_addr  <= {ADDR_W{1'b0}};
            r_wdata <= {DATA_W{1'b0}};
            r_write <= 1'b0;
            r_len   <= {LEN_W{1'b0}};
            r_beat  <= {LEN_W{1'b0}};
            r_wait  <= {WAIT_W{1'b0}};
            r_err   <= 1'b0;
            r_oor   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_write <= req_write;
                        r_len   <= req_len;
                        r_beat  <= {LEN_W{1'b0}};
                        r_wait  <= WAIT_INIT;
                        r_err   <= 1'b0;
                        r_oor   <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    r_wait <= r_wait - 3'd1;
                end
                ST_ACCESS: begin
                    r_oor <= w_oor;
                    if (w_oor) begin
                        r_err <= 1'b1;   // sticky until the next request
                    end
                end
                ST_RESP: begin
                    if (!r_write && !w_last) begin
                        r_beat <= r_beat + 3'd1;
                        r_addr <= r_addr + ADDR_W'(1'b1);   // wraps naturally
                        r_wait <= WAIT_INIT;
                    end
                end
                ST_WDATA: begin
                    if (wdata_valid) begin
                        r_wdata <= wdata;
                        r_beat  <= r_beat + 3'd1;
                        r_addr  <= r_addr + ADDR_W'(1'b1);
                        r_wait  <= WAIT_INIT;
                    end
                end
                default: begin
                    r_wait <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // Out-of-range writes are dropped; the read port still cycles but its
    // data is masked in the response.
    assign w_ram_en = (r_state == ST_ACCESS);
    assign w_ram_we = w_ram_en && r_write && !w_oor;

    mem_sp_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (r_addr[DEPTH_LOG2-1:0]),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign req_ready   = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign wdata_ready = (r_state == ST_WDATA);
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_last    = rsp_valid && w_last;
    assign rsp_err     = rsp_valid && r_err;
    assign rsp_rdata   = (rsp_valid && !r_write && !r_oor) ? w_ram_rdata
                                                           : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        proc_rst;
    // main instance, WAIT_CYC = 1
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr, req_wdata;
    logic [2:0]  req_len;
    logic        wdata_valid, wdata_ready;
    logic [15:0] wdata, rsp_rdata;
    logic        rsp_valid, rsp_last, rsp_err, busy;
    // second instance, WAIT_CYC = 0
    logic        d0_req_valid, d0_req_ready, d0_req_write;
    logic [15:0] d0_req_addr, d0_req_wdata;
    logic [2:0]  d0_req_len;
    logic        d0_wdata_valid, d0_wdata_ready;
    logic [15:0] d0_wdata, d0_rsp_rdata;
    logic        d0_rsp_valid, d0_rsp_last, d0_rsp_err, d0_busy;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int rsp_cnt = 0;

    int          q_cyc[$];
    logic [15:0] q_data[$];
    logic        q_last[$];
    logic        q_err[$];

    mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYC(1)) u_dut (
        .clk(clk), .proc_rst(proc_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last),
        .rsp_err(rsp_err), .busy(busy)
    );

    mem_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH_LOG2(8), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .proc_rst(proc_rst),
        .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_write(d0_req_write),
        .req_addr(d0_req_addr), .req_wdata(d0_req_wdata), .req_len(d0_req_len),
        .wdata_valid(d0_wdata_valid), .wdata_ready(d0_wdata_ready), .wdata(d0_wdata),
        .rsp_valid(d0_rsp_valid), .rsp_rdata(d0_rsp_rdata), .rsp_last(d0_rsp_last),
        .rsp_err(d0_rsp_err), .busy(d0_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rsp_valid === 1'b1) rsp_cnt <= rsp_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle (responder must be idle).
    task automatic issue(input logic wr, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [2:0] len, output int acc);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_len = len;
        acc = cyc;
        tick();
        req_valid = 1'b0;
    endtask

    // Record responses until the last one or until the cycle budget runs out.
    task automatic collect(input int limit);
        q_cyc.delete(); q_data.delete(); q_last.delete(); q_err.delete();
        for (int k = 0; k < limit; k++) begin
            if (rsp_valid === 1'b1) begin
                q_cyc.push_back(cyc); q_data.push_back(rsp_rdata);
                q_last.push_back(rsp_last); q_err.push_back(rsp_err);
                if (rsp_last === 1'b1) break;
            end
            tick();
        end
    endtask

    task automatic wait_wready();
        for (int k = 0; k < 20 && wdata_ready !== 1'b1; k++) tick();
        if (wdata_ready !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL wdata_ready_timeout: got %b expected 1", wdata_ready);
        end
    endtask

    // Write burst: beat 0 from the request, the rest via the wdata handshake.
    task automatic sm_burst(input logic [15:0] addr, input logic [15:0] base,
                            input logic [2:0] len, input int gap);
        int acc;
        issue(1'b1, addr, base, len, acc);
        for (int b = 1; b <= int'(len); b++) begin
            wait_wready();
            repeat (gap) tick();
            wdata_valid = 1'b1; wdata = base + 16'(b);
            tick();
            wdata_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        tests_run++; if (wdata_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_wdata_ready: got %b expected 0", wdata_ready); end
        tests_run++; if (rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        tests_run++; if (rsp_rdata !== 16'h0000) begin tests_failed++; $display("FAIL rst_rsp_rdata: got %h expected 0000", rsp_rdata); end
        tests_run++; if (rsp_last !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_last: got %b expected 0", rsp_last); end
        tests_run++; if (rsp_err !== 1'b0) begin tests_failed++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        int acc;
        issue(1'b1, 16'h0010, 16'hBEEF, 3'd0, acc);
        collect(20);
        tests_run++; if (q_cyc.size() !== 1) begin tests_failed++; $display("FAIL single_wr_count: got %0d expected 1", q_cyc.size()); end
        tests_run++; if (q_last[0] !== 1'b1) begin tests_failed++; $display("FAIL single_wr_last: got %b expected 1", q_last[0]); end
        tests_run++; if (q_data[0] !== 16'h0000) begin tests_failed++; $display("FAIL single_wr_rdata: got %h expected 0000", q_data[0]); end
        tick();
        issue(1'b0, 16'h0010, 16'h0000, 3'd0, acc);
        collect(20);
        tests_run++; if (q_cyc[0] - acc !== 3) begin tests_failed++; $display("FAIL single_rd_latency: got %0d expected 3", q_cyc[0] - acc); end
        tests_run++; if (q_data[0] !== 16'hBEEF) begin tests_failed++; $display("FAIL single_rd_rdata: got %h expected beef", q_data[0]); end
        tests_run++; if (q_err[0] !== 1'b0) begin tests_failed++; $display("FAIL single_rd_err: got %b expected 0", q_err[0]); end
        tests_run++; if (q_last[0] !== 1'b1) begin tests_failed++; $display("FAIL single_rd_last: got %b expected 1", q_last[0]); end
        tick();
    endtask

    task automatic test_burst();
        int acc;
        int c0;
        c0 = rsp_cnt;
        sm_burst(16'h0020, 16'h1000, 3'd7, 2);
        collect(20);
        tick();
        tests_run++; if (rsp_cnt - c0 !== 1) begin tests_failed++; $display("FAIL sm_pulses: got %0d expected 1", rsp_cnt - c0); end
        tests_run++; if (q_last[0] !== 1'b1) begin tests_failed++; $display("FAIL sm_last: got %b expected 1", q_last[0]); end
        issue(1'b0, 16'h0020, 16'h0000, 3'd7, acc);
        collect(60);
        tests_run++; if (q_cyc.size() !== 8) begin tests_failed++; $display("FAIL lm_count: got %0d expected 8", q_cyc.size()); end
        tests_run++; if (q_cyc[0] - acc !== 3) begin tests_failed++; $display("FAIL lm_first_latency: got %0d expected 3", q_cyc[0] - acc); end
        for (int i = 0; i < 8; i++) begin
            tests_run++; if (q_data[i] !== 16'h1000 + 16'(i)) begin tests_failed++; $display("FAIL lm_rdata[%0d]: got %h expected %h", i, q_data[i], 16'h1000 + 16'(i)); end
            tests_run++; if (q_last[i] !== (i == 7)) begin tests_failed++; $display("FAIL lm_last[%0d]: got %b expected %b", i, q_last[i], (i == 7)); end
        end
        for (int i = 1; i < 8; i++) begin
            tests_run++; if (q_cyc[i] - q_cyc[i-1] !== 3) begin tests_failed++; $display("FAIL lm_spacing[%0d]: got %0d expected 3", i, q_cyc[i] - q_cyc[i-1]); end
        end
        tick();
    endtask

    task automatic test_out_of_range();
        int acc;
        issue(1'b1, 16'h0000, 16'h5A5A, 3'd0, acc);
        collect(20);
        tests_run++; if (q_err[0] !== 1'b0) begin tests_failed++; $display("FAIL oor_inrange_wr_err: got %b expected 0", q_err[0]); end
        tick();
        issue(1'b1, 16'h0100, 16'h1234, 3'd0, acc);
        collect(20);
        tests_run++; if (q_err[0] !== 1'b1) begin tests_failed++; $display("FAIL oor_wr_err: got %b expected 1", q_err[0]); end
        tick();
        issue(1'b0, 16'h0100, 16'h0000, 3'd0, acc);
        collect(20);
        tests_run++; if (q_data[0] !== 16'h0000) begin tests_failed++; $display("FAIL oor_rd_rdata: got %h expected 0000", q_data[0]); end
        tests_run++; if (q_err[0] !== 1'b1) begin tests_failed++; $display("FAIL oor_rd_err: got %b expected 1", q_err[0]); end
        tick();
        issue(1'b0, 16'h0000, 16'h0000, 3'd0, acc);
        collect(20);
        tests_run++; if (q_data[0] !== 16'h5A5A) begin tests_failed++; $display("FAIL oor_alias_rdata: got %h expected 5a5a", q_data[0]); end
        tests_run++; if (q_err[0] !== 1'b0) begin tests_failed++; $display("FAIL oor_alias_err: got %b expected 0", q_err[0]); end
        tick();
    endtask

    task automatic test_wrap();
        int acc;
        logic [15:0] exp_d [3];
        exp_d[0] = 16'h0000; exp_d[1] = 16'h0000; exp_d[2] = 16'h5A5A;
        issue(1'b0, 16'hFFFE, 16'h0000, 3'd2, acc);
        collect(30);
        tests_run++; if (q_cyc.size() !== 3) begin tests_failed++; $display("FAIL wrap_count: got %0d expected 3", q_cyc.size()); end
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (q_data[i] !== exp_d[i]) begin tests_failed++; $display("FAIL wrap_rdata[%0d]: got %h expected %h", i, q_data[i], exp_d[i]); end
            tests_run++; if (q_err[i] !== 1'b1) begin tests_failed++; $display("FAIL wrap_err[%0d]: got %b expected 1", i, q_err[i]); end
        end
        tests_run++; if (q_last[2] !== 1'b1) begin tests_failed++; $display("FAIL wrap_last: got %b expected 1", q_last[2]); end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int acc;
        int c0;
        c0 = rsp_cnt;
        issue(1'b1, 16'h0030, 16'h2000, 3'd3, acc);
        wait_wready();
        wdata_valid = 1'b1; wdata = 16'h2001;
        tick();
        wdata_valid = 1'b0;
        wait_wready();
        proc_rst = 1'b1;
        #1;
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL midrst_req_ready: got %b expected 1", req_ready); end
        tick();
        proc_rst = 1'b0;
        repeat (4) tick();
        tests_run++; if (rsp_cnt !== c0) begin tests_failed++; $display("FAIL midrst_no_rsp: got %0d expected %0d", rsp_cnt, c0); end
        issue(1'b0, 16'h0030, 16'h0000, 3'd1, acc);
        collect(30);
        tests_run++; if (q_data[0] !== 16'h2000) begin tests_failed++; $display("FAIL midrst_rd0: got %h expected 2000", q_data[0]); end
        tests_run++; if (q_data[1] !== 16'h2001) begin tests_failed++; $display("FAIL midrst_rd1: got %h expected 2001", q_data[1]); end
        tick();
    endtask

    task automatic test_wait0_back_to_back();
        int acc;
        int offs[$];
        logic [15:0] dat[$];
        logic rdy2;
        d0_req_valid = 1'b1; d0_req_write = 1'b1; d0_req_addr = 16'h0005;
        d0_req_wdata = 16'h0077; d0_req_len = 3'd0;
        tick();
        d0_req_valid = 1'b0;
        repeat (3) tick();
        d0_req_valid = 1'b1; d0_req_write = 1'b0;
        acc = cyc;
        rdy2 = 1'b1;
        tick();
        for (int i = 1; i <= 7; i++) begin
            if (d0_rsp_valid === 1'b1) begin offs.push_back(cyc - acc); dat.push_back(d0_rsp_rdata); end
            if (i == 2) rdy2 = d0_req_ready;
            tick();
        end
        d0_req_valid = 1'b0;
        repeat (4) tick();
        tests_run++; if (offs.size() !== 2) begin tests_failed++; $display("FAIL w0_pulses: got %0d expected 2", offs.size()); end
        tests_run++; if (offs[0] !== 2) begin tests_failed++; $display("FAIL w0_latency: got %0d expected 2", offs[0]); end
        tests_run++; if (offs[1] !== 5) begin tests_failed++; $display("FAIL w0_second_rsp: got %0d expected 5", offs[1]); end
        tests_run++; if (dat[0] !== 16'h0077) begin tests_failed++; $display("FAIL w0_rdata0: got %h expected 0077", dat[0]); end
        tests_run++; if (dat[1] !== 16'h0077) begin tests_failed++; $display("FAIL w0_rdata1: got %h expected 0077", dat[1]); end
        tests_run++; if (rdy2 !== 1'b0) begin tests_failed++; $display("FAIL w0_ready_busy: got %b expected 0", rdy2); end
    endtask

    initial begin
        proc_rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000; req_len = 3'd0;
        wdata_valid = 1'b0; wdata = 16'h0000;
        d0_req_valid = 1'b0; d0_req_write = 1'b0; d0_req_addr = 16'h0000; d0_req_wdata = 16'h0000; d0_req_len = 3'd0;
        d0_wdata_valid = 1'b0; d0_wdata = 16'h0000;
        tick(); tick();
        test_reset();
        proc_rst = 1'b0;
        tick();
        test_single();
        test_burst();
        test_out_of_range();
        test_wrap();
        test_reset_mid_burst();
        test_wait0_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the multicycle processor's memory request interface.
- Accepts single-word and burst (LM/SM, up to 8 words) read/write requests from the control path.
- Inserts a configurable number of wait states and services each request against an internal single-port synchronous RAM.
- Returns read data and a completion pulse per request. Sits between the controller/datapath memory port and program/data storage.

Parameters:
- ADDR_W, 16, request address width.
- DATA_W, 16, data word width.
- DEPTH_LOG2, 8, log2 of RAM depth in words; addresses >= 2**DEPTH_LOG2 are out of range.
- WAIT_CYC, 1, wait-state cycles inserted before every beat access (0..7).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- proc_rst  in  1  asynchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  first word address.
- req_wdata  in  DATA_W  first write beat data.
- req_len  in  3  beats minus one (0 = single, 7 = 8-word burst).
- wdata_valid  in  1  subsequent write-beat data present.
- wdata_ready  out  1  responder accepts next write beat.
- wdata  in  DATA_W  subsequent write-beat data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for write completion.
- rsp_last  out  1  final response of request.
- rsp_err  out  1  at least one beat so far hit an out-of-range address; valid with rsp_valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - State goes to IDLE.
  - req_ready = 1, wdata_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_last = 0, rsp_err = 0, busy = 0.
  - Beat, wait and address registers are cleared. RAM contents are not cleared.
  - Reset asserted mid-burst abandons the request. Beats already written persist. No response is issued.
- States: IDLE, WAIT, ACCESS, RESP, WDATA.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready: latch addr, write, len and wdata; beat = 0; err = 0; wait_cnt = WAIT_CYC.
  - Next state is WAIT if WAIT_CYC > 0, else ACCESS.
- WAIT: wait_cnt decrements each cycle; when wait_cnt == 1, go to ACCESS.
- ACCESS (one cycle):
  - If address is out of range, set err; the write is suppressed and the read returns 0.
  - Read: RAM read issued; go to RESP. Data is registered and presented in RESP.
  - Write: RAM written. If beat == len, go to RESP; else go to WDATA.
- RESP (one cycle):
  - rsp_valid = 1, rsp_last = (beat == len), rsp_err = err.
  - rsp_rdata = RAM data for reads, 0 for writes.
  - Read with beat < len: beat++, addr++, reload wait_cnt, go to WAIT/ACCESS.
  - Otherwise go to IDLE.
- WDATA:
  - wdata_ready = 1.
  - On wdata_valid: latch wdata, beat++, addr++, reload wait_cnt, go to WAIT/ACCESS.
  - Holds indefinitely while wdata_valid = 0.
- Latency: request accepted at cycle N gives first read rsp_valid at cycle N+2+WAIT_CYC. Each subsequent read beat follows after 2+WAIT_CYC cycles.
- Write burst: exactly one rsp_valid pulse, rsp_last = 1, after the final beat's ACCESS.
- Address increment wraps modulo 2**ADDR_W (16'hFFFF -> 16'h0000). Range is checked per beat.
- Response acceptance: no backpressure; the requester must accept rsp_valid.
- Handshake timing:
  - req_valid is ignored while busy.
  - wdata_valid is ignored outside WDATA.
  - A new request can be accepted in the cycle after the final RESP.
- rsp_err is sticky within a request and cleared at acceptance.

Decomposition:
- Shared package mem_if_pkg:
  - State enum (IDLE, WAIT, ACCESS, RESP, WDATA).
  - LEN_W = 3, MAX_BURST = 8.
  - Default ADDR_W/DATA_W.
- One sub-module, mem_sp_array:
  - Single-port synchronous RAM with write enable and registered read.
  - Parameterised by DEPTH_LOG2 and DATA_W. No reset.

Test Plan:
- Single write then read, WAIT_CYC=1: write 16'hBEEF @16'h0010, len 0 -> one rsp_valid with rsp_last=1; read @16'h0010 accepted at N -> rsp_valid at N+3, rdata 16'hBEEF, rsp_err=0.
- 8-word SM burst @16'h0020, data 16'h1000..16'h1007 via wdata handshake with 2-cycle gaps -> single rsp_last pulse. LM burst @16'h0020 len 7 -> 8 rsp_valid pulses, rdata 16'h1000..16'h1007, rsp_last only on the 8th, pulses spaced 3 cycles apart.
- Out of range, DEPTH_LOG2=8: write 16'h1234 @16'h0100 -> rsp_err=1. Read @16'h0100 -> rdata 0, rsp_err=1. Read @16'h0000 -> unchanged.
- Wrap: read burst @16'hFFFE len 2 -> addresses FFFE, FFFF, 0000. err=1 from beat 0, remains 1 through the last beat. Third beat returns mem[0].
- Reset mid-burst: assert proc_rst during WDATA of a 4-word write after 2 beats -> next cycle busy=0, req_ready=1, rsp_valid never pulses; the 2 written words read back correctly.
- WAIT_CYC=0 and req_valid held while busy -> a single read completes in 2 cycles and the second request is accepted only after the final RESP.
